// File: rtl/step_ramp_sequencer.sv
// Trapezoidal-profile stepper sequencer: accel/cruise/decel step timing
// with its own rescheduled period counter and a 4-coil phase driver.
module step_ramp_sequencer #(
  parameter int CNT_W  = 21,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              dir,
  input  logic              half_step,
  input  logic [STEP_W-1:0] target_steps,
  input  logic [CNT_W-1:0]  period_start,
  input  logic [CNT_W-1:0]  period_min,
  input  logic [CNT_W-1:0]  ramp_step,
  output logic [3:0]        coil,
  output logic              step_pulse,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] position
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEL  = 2'd1;
  localparam logic [1:0] S_CRUISE = 2'd2;
  localparam logic [1:0] S_DECEL  = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  per;
  logic [CNT_W-1:0]  pstart;
  logic [CNT_W-1:0]  pmin;
  logic [CNT_W-1:0]  ramp;
  logic [STEP_W-1:0] target;
  logic [STEP_W-1:0] steps;
  logic [STEP_W-1:0] acc;
  logic              dir_q;
  logic              half_q;
  logic [2:0]        idx;
  logic              end_pend;

  logic [CNT_W-1:0]  ps_cl;
  logic [CNT_W-1:0]  pm_cl;
  logic              active;
  logic              step_ev;
  logic [STEP_W-1:0] steps_new;
  logic [STEP_W-1:0] acc_new;
  logic [STEP_W-1:0] remaining;
  logic [CNT_W:0]    floor_sum;
  logic [CNT_W:0]    up_sum;
  logic [CNT_W-1:0]  per_dn;
  logic [CNT_W-1:0]  per_up;
  logic [2:0]        delta;
  logic [2:0]        idx_nxt;

  assign ps_cl = (period_start < CNT_W'(2)) ? CNT_W'(2) : period_start;
  assign pm_cl = (period_min < CNT_W'(2)) ? CNT_W'(2) : period_min;

  assign active    = (state != S_IDLE);
  assign step_ev   = active && (cnt == per - CNT_W'(1));
  assign steps_new = steps + STEP_W'(1);
  assign acc_new   = (state == S_ACCEL) ? acc + STEP_W'(1) : acc;
  assign remaining = target - steps_new;

  // Widened sums keep both ramp directions free of wrap-around
  assign floor_sum = {1'b0, pmin} + {1'b0, ramp};
  assign per_dn    = ({1'b0, per} < floor_sum) ? pmin : per - ramp;
  assign up_sum    = {1'b0, per} + {1'b0, ramp};
  assign per_up    = (up_sum > {1'b0, pstart}) ? pstart
                                               : up_sum[CNT_W-1:0];

  assign delta   = half_q ? 3'd1 : 3'd2;
  assign idx_nxt = dir_q ? idx + delta : idx - delta;

  always_comb begin
    coil = 4'b1000;
    unique case (idx)
      3'd0: coil = 4'b1000;
      3'd1: coil = 4'b1100;
      3'd2: coil = 4'b0100;
      3'd3: coil = 4'b0110;
      3'd4: coil = 4'b0010;
      3'd5: coil = 4'b0011;
      3'd6: coil = 4'b0001;
      3'd7: coil = 4'b1001;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      per        <= '0;
      pstart     <= '0;
      pmin       <= '0;
      ramp       <= '0;
      target     <= '0;
      steps      <= '0;
      acc        <= '0;
      dir_q      <= 1'b0;
      half_q     <= 1'b0;
      idx        <= 3'd0;
      end_pend   <= 1'b0;
      step_pulse <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      position   <= '0;
    end else begin
      step_pulse <= 1'b0;
      done       <= 1'b0;
      if (end_pend) begin
        end_pend <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b1;
      end
      if (active && abort) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        done    <= 1'b1;
        aborted <= 1'b1;
      end else if (state == S_IDLE) begin
        if (start && !abort && !busy) begin
          dir_q   <= dir;
          half_q  <= half_step;
          target  <= target_steps;
          ramp    <= ramp_step;
          pstart  <= ps_cl;
          pmin    <= pm_cl;
          per     <= ps_cl;
          cnt     <= '0;
          steps   <= '0;
          acc     <= '0;
          aborted <= 1'b0;
          // Full-step runs only on the two-coil (odd) patterns
          if (!half_step)
            idx <= idx | 3'd1;
          if (target_steps == '0) begin
            done <= 1'b1;
          end else begin
            busy  <= 1'b1;
            state <= (ps_cl <= pm_cl) ? S_CRUISE : S_ACCEL;
          end
        end
      end else if (step_ev) begin
        cnt        <= '0;
        step_pulse <= 1'b1;
        idx        <= idx_nxt;
        steps      <= steps_new;
        position   <= dir_q ? position + STEP_W'(1)
                            : position - STEP_W'(1);
        if (steps_new == target) begin
          state    <= S_IDLE;
          end_pend <= 1'b1;
        end else begin
          unique case (state)
            S_ACCEL: begin
              acc <= acc_new;
              // Triangle turnover: hold the period for the mirror step
              if (remaining <= acc_new) begin
                state <= S_DECEL;
              end else begin
                per <= per_dn;
                if (per_dn == pmin)
                  state <= S_CRUISE;
              end
            end
            S_CRUISE: begin
              if (remaining <= acc) begin
                state <= S_DECEL;
                per   <= per_up;
              end
            end
            S_DECEL: per <= per_up;
            default: state <= S_IDLE;
          endcase
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_step_ramp_sequencer.sv
// Scoreboard bench for step_ramp_sequencer: expected step intervals,
// coil patterns and positions are queued per move and checked per pulse.
module tb_step_ramp_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        dir = 1'b1;
  logic        half_step = 1'b1;
  logic [15:0] target_steps = '0;
  logic [20:0] period_start = '0;
  logic [20:0] period_min = '0;
  logic [20:0] ramp_step = '0;
  logic [3:0]  coil;
  logic        step_pulse;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] position;

  always #5 clk = ~clk;

  step_ramp_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .dir          (dir),
    .half_step    (half_step),
    .target_steps (target_steps),
    .period_start (period_start),
    .period_min   (period_min),
    .ramp_step    (ramp_step),
    .coil         (coil),
    .step_pulse   (step_pulse),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .position     (position)
  );

  typedef struct {
    int          ival;
    logic [3:0]  coil;
    logic [15:0] pos;
  } exp_t;

  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};

  exp_t        sb [$];
  int          iv [$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last = 0;
  int          acc_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          d0 = 0;
  bit          arm = 0;
  bit          busy_seen = 0;
  bit          busy_at_done = 0;
  logic [2:0]  m_idx = 3'd0;
  logic [15:0] m_pos = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    if (start && arm) begin
      acc_cyc = cyc;
      last    = cyc;
    end
    if (busy) busy_seen = 1;
    if (step_pulse) begin
      if (sb.size() == 0) begin
        chk("extra_step", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("ival", cyc - last, e.ival);
        chk("coil", coil, e.coil);
        chk("pos", position, e.pos);
      end
      last = cyc;
    end
    if (done) begin
      done_cyc     = cyc;
      done_cnt++;
      busy_at_done = busy;
    end
  end

  task automatic add(input int v, input int n);
    repeat (n) iv.push_back(v);
  endtask

  task automatic launch(input int tgt, input bit h, input bit d,
                        input int ps, input int pm, input int rp);
    int st;
    st = h ? 1 : 2;
    if (!h) m_idx = m_idx | 3'd1;
    foreach (iv[i]) begin
      m_idx = d ? m_idx + st[2:0] : m_idx - st[2:0];
      m_pos = d ? m_pos + 16'd1 : m_pos - 16'd1;
      sb.push_back('{iv[i], tbl[m_idx], m_pos});
    end
    iv.delete();
    @(negedge clk); #1;
    target_steps = tgt[15:0];
    half_step    = h;
    dir          = d;
    period_start = ps[20:0];
    period_min   = pm[20:0];
    ramp_step    = rp[20:0];
    d0           = done_cnt;
    start        = 1'b1;
    arm          = 1;
    @(negedge clk); #1;
    start = 1'b0;
    arm   = 0;
    if (tgt != 0) chk("busy_on", busy, 1);
  endtask

  task automatic finish_move();
    int t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("done_seen", done_cnt != d0, 1);
    chk("done_lat", done_cyc - last, 1);
    chk("busy_at_done", busy_at_done, 0);
    chk("sb_empty", sb.size(), 0);
    chk("end_coil", coil, tbl[m_idx]);
    chk("end_pos", position, m_pos);
    @(negedge clk); #1;
    chk("done_1cyc", done, 0);
  endtask

  task automatic wait_sb(input int n);
    int t = 0;
    while (sb.size() > n && t < 5000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("wait_sb", sb.size() > n, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk); #1;
    rst   = 1'b0;
    m_idx = 3'd0;
    m_pos = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_coil"}, coil, 4'b1000);
    chk({tag, "_pulse"}, step_pulse, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_abrt"}, aborted, 0);
    chk({tag, "_pos"}, position, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    do_reset();
    chk_reset("rst");

    // constant-speed half-step move
    add(8, 10);
    launch(10, 1, 1, 8, 8, 1);
    finish_move();
    chk("t1_coil", coil, 4'b0100);
    chk("t1_pos", position, 16'd10);

    // trapezoid
    add(10, 1); add(8, 1); add(6, 1); add(4, 14);
    add(6, 1); add(8, 1); add(10, 1);
    launch(20, 1, 1, 10, 4, 2);
    finish_move();

    // triangle
    add(10, 1); add(7, 2); add(10, 1);
    launch(4, 1, 1, 10, 2, 3);
    finish_move();

    // full-step reverse from reset
    do_reset();
    chk_reset("rst2");
    add(6, 5);
    launch(5, 0, 0, 6, 6, 1);
    chk("t4_first", coil, 4'b1100);
    finish_move();
    chk("t4_pos", position, 16'hFFFB);
    chk("t4_coil", coil, 4'b1001);

    // abort on third step's terminal-count cycle
    add(8, 2);
    launch(10, 1, 1, 8, 8, 1);
    wait_sb(0);
    repeat (7) @(negedge clk);
    #1 abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    chk("ab_done", done, 1);
    chk("ab_flag", aborted, 1);
    chk("ab_busy", busy, 0);
    chk("ab_pulse", step_pulse, 0);
    chk("ab_pos", position, m_pos);
    chk("ab_coil", coil, tbl[m_idx]);
    repeat (20) @(negedge clk);
    #1;
    chk("ab_hold", aborted, 1);
    chk("ab_idle", busy, 0);

    // zero-length move
    busy_seen = 0;
    launch(0, 1, 1, 8, 8, 1);
    chk("t0_abclr", aborted, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("t0_done", done_cnt - d0, 1);
    chk("t0_lat", done_cyc - acc_cyc, 0);
    chk("t0_busy", busy_seen, 0);
    chk("t0_pos", position, m_pos);

    // start while busy is ignored
    add(5, 3);
    launch(3, 1, 1, 5, 5, 1);
    wait_sb(2);
    target_steps = 16'd1;
    period_start = 21'd2;
    start        = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    finish_move();

    // reset mid-move
    add(6, 10);
    launch(10, 1, 1, 6, 6, 1);
    wait_sb(8);
    do_reset();
    chk_reset("rst3");
    repeat (20) @(negedge clk);
    #1;
    chk("rst3_quiet", busy_seen && busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
